// File: rtl/if_stage_pkg.sv
// Shared fetch-pipeline types: FSM state, NOP encoding, fetch bundle.
// Imported by if_stage and if_skid_buf.
package if_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instruction;
  } fetch_bundle_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer for a fetched bundle that arrives while IF/ID stalls.
// Ports: clr (flush), wr_en/wdata (store), rd_en (drain), full/rdata.
module if_skid_buf
  import if_stage_pkg::*;
#(
  parameter type T = fetch_bundle_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wr_en,
  input  T     wdata,
  input  logic rd_en,
  output logic full,
  output T     rdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      rdata <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full  <= 1'b1;
      rdata <= wdata;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem FSM, output bundle.
// Ports: clk/rst_n, stall_i, redirect_i/redirect_pc_i, imem_* request and
// response, pc_o/pc_plus4_o/instruction_o/valid_o bundle, misalign_o.
// Build macro IF_MISALIGN_CHECK_EN: drop misaligned redirects and flag them.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  valid_o,
  output logic                  misalign_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] instruction;
  } bundle_t;

  if_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, addr_q;
  logic [DATA_WIDTH-1:0] redir_tgt;
  logic                  kill_q, valid_q, redir;
  logic                  rsp_take, rsp_skid, rsp_load, skid_pop;
  logic                  skid_full;
  bundle_t               out_q, rsp_b, skid_b;

`ifdef IF_MISALIGN_CHECK_EN
  logic mis_req, mis_q;
  assign mis_req   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign redir     = redirect_i && !mis_req;
  assign redir_tgt = redirect_pc_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_req;
  end
  assign misalign_o = mis_q;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc_i[1:0];
  assign redir      = redirect_i;
  assign redir_tgt  = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
  assign misalign_o = 1'b0;
`endif

  // A response is only usable if no redirect overtook it.
  assign rsp_take = (state_q == WAIT) && imem_rvalid_i
                  && !kill_q && !redir;
  assign rsp_skid = rsp_take && stall_i && valid_q;
  assign rsp_load = rsp_take && !rsp_skid;
  assign skid_pop = (state_q == HOLD) && skid_full
                  && !stall_i && !redir;

  assign rsp_b = '{pc:          addr_q,
                   pc_plus4:    addr_q + DATA_WIDTH'(4),
                   instruction: imem_rdata_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_gnt_i) state_d = WAIT;
      WAIT: if (imem_rvalid_i) state_d = rsp_skid ? HOLD : REQ;
      HOLD: if (redir || !stall_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    if (state_q == REQ) imem_req_o = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      addr_q <= '0;
      kill_q <= 1'b0;
    end else begin
      if (state_q == REQ && imem_gnt_i) begin
        addr_q <= pc_q;
        kill_q <= redir;
      end else if (state_q == WAIT) begin
        if (imem_rvalid_i) kill_q <= 1'b0;
        else if (redir)    kill_q <= 1'b1;
      end
      if (redir)         pc_q <= redir_tgt;
      else if (rsp_take) pc_q <= addr_q + DATA_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '{pc: '0, pc_plus4: '0,
                   instruction: DATA_WIDTH'(NOP_INSN)};
    end else if (redir) begin
      valid_q <= 1'b0;
    end else if (rsp_load) begin
      valid_q <= 1'b1;
      out_q   <= rsp_b;
    end else if (skid_pop) begin
      valid_q <= 1'b1;
      out_q   <= skid_b;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

  if_skid_buf #(
    .T(bundle_t)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redir),
    .wr_en (rsp_skid),
    .wdata (rsp_b),
    .rd_en (skid_pop),
    .full  (skid_full),
    .rdata (skid_b)
  );

  assign pc_o          = out_q.pc;
  assign pc_plus4_o    = out_q.pc_plus4;
  assign instruction_o = out_q.instruction;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: transaction-level fetch model plus directed scenarios.
// Build with or without IF_MISALIGN_CHECK_EN to match the DUT.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o, pc_plus4_o, instruction_o;
  logic        valid_o, misalign_o;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instruction_o (instruction_o),
    .valid_o       (valid_o),
    .misalign_o    (misalign_o)
  );

  typedef struct {
    logic [31:0] addr;
    bit          killed;
  } ost_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
  } bun_t;

  int tests = 0;
  int fails = 0;

  // model state
  logic [31:0] model_pc;
  ost_t        ost[$];
  bun_t        expq[$];
  bun_t        cur;
  bit          cur_v, exp_mis, new_pres;

  // logs of observed DUT behaviour
  logic [31:0] req_log[$];
  bun_t        out_log[$];
  int          mis_seen = 0;

  // memory responder
  int          lat = 1;
  bit          gnt_en = 1'b1;
  bit          pend_act = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  // inputs applied at the last edge
  logic        c_req, c_gnt, c_rv, c_st, c_rd;
  logic [31:0] c_addr, c_rpc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rq(input int i);
    if (i < req_log.size()) return req_log[i];
    return 'x;
  endfunction

  function automatic bun_t ou(input int i);
    if (i < out_log.size()) return out_log[i];
    return 'x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_pc = 32'h0;
    ost.delete();
    expq.delete();
    cur_v    = 1'b0;
    exp_mis  = 1'b0;
    new_pres = 1'b0;
  endtask

  task automatic model_update();
    bit          eff, mis;
    logic [31:0] tgt;
    ost_t        o;
`ifdef IF_MISALIGN_CHECK_EN
    mis = c_rd && (c_rpc[1:0] != 2'b00);
    eff = c_rd && !mis;
    tgt = c_rpc;
`else
    mis = 1'b0;
    eff = c_rd;
    tgt = c_rpc & ~32'h3;
`endif
    exp_mis  = mis;
    new_pres = 1'b0;
    if (c_rv && ost.size() > 0) begin
      o = ost.pop_front();
      if (!o.killed && !eff) begin
        expq.push_back('{o.addr, o.addr + 32'd4, mem(o.addr)});
        model_pc = o.addr + 32'd4;
      end
    end
    if (c_req && c_gnt) ost.push_back('{c_addr, eff});
    if (eff) begin
      foreach (ost[i]) ost[i].killed = 1'b1;
      expq.delete();
      cur_v    = 1'b0;
      model_pc = tgt;
    end else if (c_st && cur_v) begin
      // downstream holds the current bundle
    end else if (expq.size() > 0) begin
      cur      = expq.pop_front();
      cur_v    = 1'b1;
      new_pres = 1'b1;
    end else begin
      cur_v = 1'b0;
    end
  endtask

  task automatic compare();
    if (imem_req_o) begin
      chk("req_addr", imem_addr_o, model_pc);
      chk("req_single", 32'(ost.size()), 32'd0);
    end
    chk("valid", {31'b0, valid_o}, {31'b0, cur_v});
    if (cur_v) begin
      chk("pc", pc_o, cur.pc);
      chk("pc_plus4", pc_plus4_o, cur.pc4);
      chk("instr", instruction_o, cur.ins);
    end
    chk("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
    if (misalign_o === 1'b1) mis_seen++;
    if (new_pres && valid_o)
      out_log.push_back('{pc_o, pc_plus4_o, instruction_o});
  endtask

  task automatic tick(input logic st, input logic rd,
                      input logic [31:0] rpc);
    logic        g, rv;
    logic [31:0] dat;
    rv  = 1'b0;
    dat = '0;
    if (pend_act) begin
      if (pend_cnt == 0) begin
        rv       = 1'b1;
        dat      = mem(pend_addr);
        pend_act = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    g = gnt_en && imem_req_o;
    if (g) begin
      pend_act  = 1'b1;
      pend_addr = imem_addr_o;
      pend_cnt  = lat - 1;
      req_log.push_back(imem_addr_o);
    end
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = dat;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    c_req  = imem_req_o;
    c_addr = imem_addr_o;
    c_gnt  = g;
    c_rv   = rv;
    c_st   = st;
    c_rd   = rd;
    c_rpc  = rpc;
    @(negedge clk);
    model_update();
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input bit clr_pend);
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    if (clr_pend) pend_act = 1'b0;
    #1;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc4", pc_plus4_o, 32'h0);
    chk("rst_instr", instruction_o, 32'h0000_0013);
    chk("rst_mis", {31'b0, misalign_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_wait();
    int k = 0;
    while (ost.size() == 0 && k < 50) begin
      run(1);
      k++;
    end
    chk("timeout_wait", 32'(ost.size()), 32'd1);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem_req_o && k < 50) begin
      run(1);
      k++;
    end
    chk("timeout_req", {31'b0, imem_req_o}, 32'd1);
  endtask

  task automatic wait_vr();
    int k = 0;
    while (!(valid_o && imem_req_o) && k < 50) begin
      run(1);
      k++;
    end
    chk("timeout_vr", {31'b0, valid_o && imem_req_o}, 32'd1);
  endtask

  initial begin
    int          mr, mo, ms;
    logic [31:0] oaddr;
    logic [31:0] seq[5];
    seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    @(negedge clk);

    // reset release, back-to-back fetch
    do_reset(1'b1);
    lat    = 1;
    gnt_en = 1'b1;
    run(8);
    chk("seq_req0", rq(0), 32'h0);
    chk("seq_req1", rq(1), 32'h4);
    chk("seq_req2", rq(2), 32'h8);
    chk("seq_out_pc", ou(0).pc, 32'h0);
    chk("seq_out_pc4", ou(0).pc4, 32'h4);
    chk("seq_out_ins", ou(0).ins, 32'h1357_9BDF);

    // stall across a returning response
    wait_vr();
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    run(8);
    foreach (seq[i]) begin
      chk("stall_seq_pc", ou(i).pc, seq[i]);
      chk("stall_seq_ins", ou(i).ins, mem(seq[i]));
    end

    // redirect while waiting on memory
    lat = 3;
    wait_wait();
    mr = req_log.size();
    mo = out_log.size();
    tick(1'b0, 1'b1, 32'h100);
    run(14);
    chk("redir_req", rq(mr), 32'h100);
    chk("redir_out", ou(mo).pc, 32'h100);
    chk("redir_out2", ou(mo + 1).pc, 32'h104);

    // redirect in the same cycle as grant
    lat = 2;
    wait_req();
    mr = req_log.size();
    mo = out_log.size();
    tick(1'b0, 1'b1, 32'h200);
    run(12);
    chk("gnt_redir_req", rq(mr + 1), 32'h200);
    chk("gnt_redir_out", ou(mo).pc, 32'h200);

    // wrap at the top of the address space
    lat = 1;
    wait_req();
    gnt_en = 1'b0;
    mo = out_log.size();
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    gnt_en = 1'b1;
    run(8);
    chk("wrap_pc", ou(mo).pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", ou(mo).pc4, 32'h0);
    chk("wrap_next", ou(mo + 1).pc, 32'h0);
    chk("wrap_ins", ou(mo + 1).ins, 32'h1357_9BDF);

    // misaligned redirect target
    lat = 2;
    wait_wait();
    oaddr = ost[0].addr;
    mo = out_log.size();
    ms = mis_seen;
    tick(1'b0, 1'b1, 32'h102);
    run(10);
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_pulse", 32'(mis_seen - ms), 32'd1);
    chk("mis_cont", ou(mo).pc, oaddr);
`else
    chk("mis_pulse", 32'(mis_seen - ms), 32'd0);
    chk("mis_align", ou(mo).pc, 32'h100);
`endif

    // reset with a request in flight; late response must be ignored
    lat = 4;
    wait_wait();
    do_reset(1'b0);
    mr = req_log.size();
    mo = out_log.size();
    gnt_en = 1'b0;
    run(6);
    gnt_en = 1'b1;
    run(10);
    chk("rst_mid_req", rq(mr), 32'h0);
    chk("rst_mid_pc", ou(mo).pc, 32'h0);
    chk("rst_mid_ins", ou(mo).ins, 32'h1357_9BDF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
